// File: rtl/uart_tx_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : 16550A-style serial transmit engine. Accepts one character at a
//            time over a valid/ready handshake and shifts it out as start,
//            5..8 data bits (LSB first), optional parity and 1/1.5/2 stop bits,
//            timed by a 16x oversampling baud tick.
// Ports    : clk_i, rst_i        - clock, synchronous active-high reset
//            baud_tick_i         - one-cycle oversampling tick
//            data_i/_valid_i     - character from the TX FIFO
//            data_ready_o        - engine idle and able to take a character
//            word_len_i, stop_bits_i, par_en_i, even_par_i, force_par_i,
//            set_break_i         - live LCR framing fields
//            txd_o               - registered serial line (idle high)
//            tx_empty_o          - shift register empty (LSR bit 6)
//            tx_done_o           - one-cycle pulse at end of last stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
  parameter int OversampleRate = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       baud_tick_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  input  logic [1:0] word_len_i,
  input  logic       stop_bits_i,
  input  logic       par_en_i,
  input  logic       even_par_i,
  input  logic       force_par_i,
  input  logic       set_break_i,
  output logic       txd_o,
  output logic       tx_empty_o,
  output logic       tx_done_o
);

  localparam int CNT_W = $clog2(OversampleRate);
  // Last tick count of a full bit and of the half bit used for 1.5 stop bits.
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OversampleRate - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OversampleRate / 2 - 1);

  typedef enum logic [2:0] {
    TXIDLE   = 3'd0,
    TXSTART  = 3'd1,
    TXDATA   = 3'd2,
    TXPAR    = 3'd3,
    TXSTOP1  = 3'd4,
    TXSTOP2  = 3'd5,
    TXFINISH = 3'd6
  } state_type_tx;

  state_type_tx     state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       word_len_q, word_len_d;
  logic             stop_bits_q, stop_bits_d;
  logic             par_en_q, par_en_d;
  logic             even_par_q, even_par_d;
  logic             force_par_q, force_par_d;
  logic             txd_q, txd_d;
  logic             tx_empty_q;
  logic             tx_done_q;

  logic             xfer;
  logic             last_bit;
  logic             bit_end;
  logic [CNT_W-1:0] tick_last;
  logic [7:0]       data_mask;
  logic             par_raw;
  logic             par_bit;
  logic             line_lvl;

  assign data_ready_o = (state_q == TXIDLE) && !rst_i;
  assign xfer         = data_valid_i && data_ready_o;

  // Data bit index N-1 is word_len+4.
  assign last_bit  = (bit_cnt_q == ({1'b0, word_len_q} + 3'd4));
  // Only the second stop bit of a 5-bit frame is shortened to half a bit.
  assign tick_last = ((state_q == TXSTOP2) && (word_len_q == 2'b00)) ? HALF_LAST : FULL_LAST;
  assign bit_end   = baud_tick_i && (tick_cnt_q == tick_last);

  // Parity covers only the N transmitted bits; upper latched bits are masked.
  assign data_mask = 8'hFF >> (2'd3 - word_len_q);
  assign par_raw   = ^(data_q & data_mask);
  assign par_bit   = force_par_q ? ~even_par_q : (even_par_q ? par_raw : ~par_raw);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    word_len_d  = word_len_q;
    stop_bits_d = stop_bits_q;
    par_en_d    = par_en_q;
    even_par_d  = even_par_q;
    force_par_d = force_par_q;
    line_lvl    = 1'b1;

    case (state_q)
      TXIDLE: begin
        if (xfer) begin
          data_d      = data_i;
          word_len_d  = word_len_i;
          stop_bits_d = stop_bits_i;
          par_en_d    = par_en_i;
          even_par_d  = even_par_i;
          force_par_d = force_par_i;
          bit_cnt_d   = 3'd0;
          tick_cnt_d  = '0;
          state_d     = TXSTART;
        end
      end

      TXFINISH: begin
        tick_cnt_d = '0;
        state_d    = TXIDLE;
      end

      default: begin
        // Bit-timed states: count ticks, restart the count on every bit.
        if (baud_tick_i) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
        if (bit_end) begin
          tick_cnt_d = '0;
          case (state_q)
            TXSTART: state_d = TXDATA;
            TXDATA: begin
              if (last_bit) begin
                state_d = par_en_q ? TXPAR : TXSTOP1;
              end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end
            TXPAR:   state_d = TXSTOP1;
            TXSTOP1: state_d = stop_bits_q ? TXSTOP2 : TXFINISH;
            default: state_d = TXFINISH;
          endcase
        end
      end
    endcase

    case (state_q)
      TXSTART: line_lvl = 1'b0;
      TXDATA:  line_lvl = data_q[bit_cnt_q];
      TXPAR:   line_lvl = par_bit;
      default: line_lvl = 1'b1;
    endcase

    // Break overrides the line but never stalls the state machine.
    txd_d = set_break_i ? 1'b0 : line_lvl;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= TXIDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= 3'd0;
      data_q      <= 8'h00;
      word_len_q  <= 2'b00;
      stop_bits_q <= 1'b0;
      par_en_q    <= 1'b0;
      even_par_q  <= 1'b0;
      force_par_q <= 1'b0;
      txd_q       <= 1'b1;
      tx_empty_q  <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      word_len_q  <= word_len_d;
      stop_bits_q <= stop_bits_d;
      par_en_q    <= par_en_d;
      even_par_q  <= even_par_d;
      force_par_q <= force_par_d;
      txd_q       <= txd_d;
      // Status outputs share the one-clock lag of txd_o so all three line up.
      tx_empty_q  <= (state_q == TXIDLE);
      tx_done_q   <= (state_q == TXFINISH);
    end
  end

  assign txd_o      = txd_q;
  assign tx_empty_o = tx_empty_q;
  assign tx_done_o  = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_engine
// Purpose  : Self-checking bench for uart_tx_engine. Expected line levels are
//            built per baud tick from the framing rules and compared against
//            txd_o sampled one clock after each tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

  localparam int OSR = 16;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       baud_tick = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready_o;
  logic [1:0] word_len = 2'b11;
  logic       stop_bits = 1'b0;
  logic       par_en = 1'b0;
  logic       even_par = 1'b0;
  logic       force_par = 1'b0;
  logic       set_break = 1'b0;
  logic       txd_o;
  logic       tx_empty_o;
  logic       tx_done_o;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic exp_q[$];
  logic got_q[$];
  logic lat_txd0, lat_emp0, lat_txd1, lat_emp1;
  int   ready_hits, done_hits;
  bit   timed_out;
  logic done_now, rdy_now, done_after, empty_after;

  uart_tx_engine #(.OversampleRate(OSR)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .baud_tick_i  (baud_tick),
    .data_i       (data),
    .data_valid_i (data_valid),
    .data_ready_o (data_ready_o),
    .word_len_i   (word_len),
    .stop_bits_i  (stop_bits),
    .par_en_i     (par_en),
    .even_par_i   (even_par),
    .force_par_i  (force_par),
    .set_break_i  (set_break),
    .txd_o        (txd_o),
    .tx_empty_o   (tx_empty_o),
    .tx_done_o    (tx_done_o)
  );

  always #5 clk = ~clk;

  // Baud ticks: one-cycle pulses separated by at least two idle cycles.
  initial begin
    forever begin
      @(posedge clk); #2; baud_tick = 1'b1;
      @(posedge clk); #2; baud_tick = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
    end
  end

  always @(posedge clk) if (tx_done_o) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: one entry per baud tick of the frame, holding the line level.
  task automatic build_exp(input logic [7:0] d, input logic [1:0] wl, input logic sb,
                           input logic pe, input logic ep, input logic fp,
                           input int brk_start, input int brk_len);
    int   n;
    logic p;
    exp_q.delete();
    n = int'(wl) + 5;
    repeat (OSR) exp_q.push_back(1'b0);
    for (int k = 0; k < n; k++) repeat (OSR) exp_q.push_back(d[k]);
    if (pe) begin
      p = 1'b0;
      for (int k = 0; k < n; k++) p = p ^ d[k];
      repeat (OSR) exp_q.push_back(fp ? ~ep : (ep ? p : ~p));
    end
    repeat (OSR) exp_q.push_back(1'b1);
    if (sb) repeat ((n == 5) ? OSR / 2 : OSR) exp_q.push_back(1'b1);
    if (brk_len > 0)
      for (int i = brk_start + 1; i <= brk_start + brk_len && i < exp_q.size(); i++) exp_q[i] = 1'b0;
  endtask

  // Starts on the first negedge after the transfer edge; records txd one
  // clock after every tick. Optionally drives break or reset mid-frame.
  task automatic collect(input int n, input int brk_start, input int brk_len, input int abort_at);
    int   cyc;
    logic pending;
    got_q.delete();
    ready_hits = 0; done_hits = 0; timed_out = 0; pending = 1'b0; cyc = 0;
    while (got_q.size() < n) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 0) begin lat_txd0 = txd_o; lat_emp0 = tx_empty_o; end
      if (cyc == 1) begin lat_txd1 = txd_o; lat_emp1 = tx_empty_o; end
      if (data_ready_o) ready_hits++;
      if (tx_done_o) done_hits++;
      if (pending) begin
        got_q.push_back(txd_o);
        if (brk_len > 0 && got_q.size() - 1 == brk_start) set_break = 1'b1;
        if (brk_len > 0 && got_q.size() - 1 == brk_start + brk_len) set_break = 1'b0;
        if (got_q.size() - 1 == abort_at) begin rst_i = 1'b1; break; end
      end
      pending = baud_tick;
      cyc++;
      if (cyc > 20000) begin timed_out = 1'b1; break; end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] wl, input logic sb,
                      input logic pe, input logic ep, input logic fp,
                      input int brk_start, input int brk_len, input int abort_at, input bit scramble);
    int w;
    build_exp(d, wl, sb, pe, ep, fp, brk_start, brk_len);
    w = 0;
    @(negedge clk);
    while (!data_ready_o && w < 200) begin @(negedge clk); w++; end
    data = d; word_len = wl; stop_bits = sb; par_en = pe; even_par = ep; force_par = fp;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    if (scramble) {word_len, stop_bits, par_en, even_par, force_par} = 6'($urandom);
    @(negedge clk);
    collect((abort_at >= 0) ? abort_at + 1 : exp_q.size(), brk_start, brk_len, abort_at);
  endtask

  task automatic tail();
    @(negedge clk);
    done_now = tx_done_o; rdy_now = data_ready_o;
    @(negedge clk);
    done_after = tx_done_o; empty_after = tx_empty_o;
  endtask

  // -1: match; -2: wrong sample count or timeout; else first bad tick index.
  function automatic int first_mismatch(input int n);
    if (timed_out || got_q.size() != n || exp_q.size() < n) return -2;
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; data_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (txd_o !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd_o); end
    checks++; if (tx_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", tx_empty_o); end
    checks++; if (tx_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_done_o); end
    checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", data_ready_o); end
    rst_i = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    checks++; if (data_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", data_ready_o); end
  endtask

  task automatic test_8n1();
    int mm;
    send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1, 1'b0);
    checks++;
    if ({lat_txd0, lat_emp0, lat_txd1, lat_emp1} !== 4'b1100) begin
      errors++; $display("FAIL 8n1_latency: txd/empty got %b%b then %b%b want 11 then 00", lat_txd0, lat_emp0, lat_txd1, lat_emp1);
    end
    mm = first_mismatch(exp_q.size());
    checks++; if (mm != -1) begin errors++; $display("FAIL 8n1_frame: first bad tick %0d (samples %0d want %0d)", mm, got_q.size(), exp_q.size()); end
    checks++; if (ready_hits != 0) begin errors++; $display("FAIL 8n1_ready_busy: ready high %0d cycles want 0", ready_hits); end
    checks++; if (done_hits != 0) begin errors++; $display("FAIL 8n1_early_done: got %0d pulses want 0", done_hits); end
    tail();
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL 8n1_done: got %b want 1", done_now); end
    checks++; if ({done_after, empty_after} !== 2'b01) begin errors++; $display("FAIL 8n1_done_end: done/empty got %b%b want 01", done_after, empty_after); end
  endtask

  task automatic test_7e1();
    int mm;
    for (int ep = 0; ep < 2; ep++) begin
      send(8'h41, 2'b10, 1'b0, 1'b1, ep[0], 1'b0, -1, 0, -1, 1'b0);
      mm = first_mismatch(exp_q.size());
      checks++; if (mm != -1) begin errors++; $display("FAIL 7p1_frame ep=%0d: first bad tick %0d", ep, mm); end
      checks++;
      if (got_q.size() <= 128 || got_q[128] !== ~ep[0]) begin
        errors++; $display("FAIL 7p1_parity ep=%0d: got %b want %b", ep, (got_q.size() > 128) ? got_q[128] : 1'bx, ~ep[0]);
      end
      tail();
      checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL 7p1_done ep=%0d: got %b want 1", ep, done_now); end
    end
  endtask

  task automatic test_stick_parity();
    int mm;
    send(8'h1F, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0, -1, 1'b0);
    mm = first_mismatch(exp_q.size());
    checks++; if (mm != -1) begin errors++; $display("FAIL stick_frame: first bad tick %0d", mm); end
    checks++;
    if (got_q.size() <= 96 || got_q[96] !== 1'b0) begin
      errors++; $display("FAIL stick_parity: got %b want 0", (got_q.size() > 96) ? got_q[96] : 1'bx);
    end
    checks++; if (done_hits != 0) begin errors++; $display("FAIL stick_early_done: got %0d want 0", done_hits); end
    tail();
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL stick_done_at_136: got %b want 1", done_now); end
  endtask

  task automatic test_random();
    int         mm;
    logic [7:0] d;
    logic [5:0] l;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom); l = 6'($urandom);
      send(d, l[5:4], l[3], l[2], l[1], l[0], -1, 0, -1, 1'b1);
      mm = first_mismatch(exp_q.size());
      checks++; if (mm != -1) begin errors++; $display("FAIL rand_frame %0d: data %h lcr %b first bad tick %0d", i, d, l, mm); end
      tail();
      checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL rand_done %0d: got %b want 1", i, done_now); end
    end
  endtask

  task automatic test_back_to_back();
    int mm, base, w;
    base = done_cnt;
    build_exp(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    w = 0;
    @(negedge clk);
    while (!data_ready_o && w < 200) begin @(negedge clk); w++; end
    data = 8'h55; word_len = 2'b11; stop_bits = 1'b0; par_en = 1'b0; even_par = 1'b0; force_par = 1'b0;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data = 8'h00;
    @(negedge clk);
    collect(exp_q.size(), -1, 0, -1);
    mm = first_mismatch(exp_q.size());
    checks++; if (mm != -1) begin errors++; $display("FAIL b2b_frame1: first bad tick %0d", mm); end
    checks++; if (ready_hits != 0) begin errors++; $display("FAIL b2b_ready_busy1: ready high %0d cycles want 0", ready_hits); end
    @(negedge clk);
    checks++; if ({tx_done_o, data_ready_o} !== 2'b11) begin errors++; $display("FAIL b2b_done_ready: done/ready got %b%b want 11", tx_done_o, data_ready_o); end
    build_exp(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    @(negedge clk);
    data_valid = 1'b0;
    collect(exp_q.size(), -1, 0, -1);
    checks++; if ({lat_txd0, lat_txd1} !== 2'b10) begin errors++; $display("FAIL b2b_gap: txd got %b%b want 10", lat_txd0, lat_txd1); end
    mm = first_mismatch(exp_q.size());
    checks++; if (mm != -1) begin errors++; $display("FAIL b2b_frame2: first bad tick %0d", mm); end
    checks++; if (ready_hits != 0) begin errors++; $display("FAIL b2b_ready_busy2: ready high %0d cycles want 0", ready_hits); end
    tail();
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - base != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - base); end
  endtask

  task automatic test_break();
    int mm;
    send(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 39, 40, -1, 1'b0);
    mm = first_mismatch(exp_q.size());
    checks++; if (mm != -1) begin errors++; $display("FAIL break_frame: first bad tick %0d", mm); end
    checks++;
    if (got_q.size() <= 100 || got_q[100] !== 1'b1) begin
      errors++; $display("FAIL break_release: got %b want 1", (got_q.size() > 100) ? got_q[100] : 1'bx);
    end
    tail();
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL break_done: got %b want 1", done_now); end
    set_break = 1'b1;
    @(negedge clk);
    checks++; if (txd_o !== 1'b0) begin errors++; $display("FAIL break_idle: got %b want 0", txd_o); end
    set_break = 1'b0;
    @(negedge clk);
    checks++; if (txd_o !== 1'b1) begin errors++; $display("FAIL break_idle_release: got %b want 1", txd_o); end
  endtask

  task automatic test_reset_mid_frame();
    int mm, base;
    base = done_cnt;
    send(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 69, 1'b0);
    mm = first_mismatch(70);
    checks++; if (mm != -1) begin errors++; $display("FAIL rst_partial: first bad tick %0d", mm); end
    #1;
    checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_comb: got %b want 0", data_ready_o); end
    @(negedge clk);
    checks++;
    if ({txd_o, tx_empty_o, tx_done_o, data_ready_o} !== 4'b1100) begin
      errors++; $display("FAIL rst_mid_state: txd/empty/done/ready got %b%b%b%b want 1100", txd_o, tx_empty_o, tx_done_o, data_ready_o);
    end
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (done_cnt != base) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - base); end
    send(8'h96, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0, -1, 1'b0);
    mm = first_mismatch(exp_q.size());
    checks++; if (mm != -1) begin errors++; $display("FAIL rst_recover_frame: first bad tick %0d", mm); end
    tail();
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL rst_recover_done: got %b want 1", done_now); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1();
    test_stick_parity();
    test_random();
    test_back_to_back();
    test_break();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
